// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, arbiter state encodings and carry-out helper
package alu_pkg;
  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;
  typedef enum logic {ST_ARB, ST_LOCKED} state_t;
  // Carry (ADC) or borrow (SUB) recovered from operand and result sign bits
  function automatic logic alu_cout(input logic [1:0] op, input logic a7, input logic b7, input logic y7);
    return op == OP_ADC ? ((a7 & b7) | ((a7 | b7) & ~y7)) :
           op == OP_SUB ? ((~a7 & b7) | ((~a7 | b7) & y7)) : 1'b0;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, first candidate at or after ptr with wrap
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Scan offsets from far to near so the nearest candidate wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit ALU with lock bursts and carry chaining
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cy,
  input  logic [NREQ-1:0]   req_chain,
  input  logic [NREQ-1:0]   req_lock,
  output logic [1:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_cy,
  input  logic [7:0]        alu_y,
  input  logic              alu_st,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_y,
  output logic              rsp_st,
  output logic              rsp_cout
);
  localparam int IW = NREQ > 2 ? 2 : 1;
  state_t          state;
  logic [IW-1:0]   ptr, owner, idx, nxt;
  logic [NREQ-1:0] cand, gnt, owner_oh;
  logic [7:0]      tmo_cnt;
  logic            carry_q, acc, cout, lock_g;
  assign owner_oh = NREQ'(1) << owner;
  assign cand     = state == ST_LOCKED ? (req_valid & owner_oh) : req_valid;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (.cand(cand), .ptr(ptr), .gnt(gnt), .idx(idx));
  assign req_ready = rst_n ? gnt : '0;
  assign acc       = |req_ready;
  assign alu_op    = acc ? req_op[{idx, 1'b0} +: 2] : OP_PASS;
  assign alu_a     = acc ? req_a[{idx, 3'b000} +: 8] : 8'h00;
  assign alu_b     = acc ? req_b[{idx, 3'b000} +: 8] : 8'h00;
  assign alu_cy    = acc & (req_chain[idx] ? carry_q : req_cy[idx]);
  assign cout      = alu_cout(alu_op, alu_a[7], alu_b[7], alu_y[7]);
  assign lock_g    = req_lock[idx];
  assign nxt       = idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      ptr       <= '0;
      owner     <= '0;
      carry_q   <= 1'b0;
      tmo_cnt   <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_st    <= 1'b0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= acc ? gnt : '0;
      if (acc) begin
        rsp_y    <= alu_y;
        rsp_st   <= alu_st;
        rsp_cout <= cout;
        carry_q  <= cout;
        ptr      <= nxt;
      end
      if (state == ST_ARB) begin
        if (acc && lock_g) begin
          state   <= ST_LOCKED;
          owner   <= idx;
          tmo_cnt <= '0;
        end
      end else if (acc) begin
        tmo_cnt <= '0;
        if (!lock_g) state <= ST_ARB;
      end else if (tmo_cnt + 8'd1 == 8'(LOCK_TMO)) begin
        // Idle owner forfeits the lock; a stale chain carry must not leak to the next client
        state   <= ST_ARB;
        tmo_cnt <= '0;
        carry_q <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, chaining, lock timeout and reset
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int NREQ = 2;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_cy, req_chain, req_lock, rsp_valid;
  logic [2*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [1:0]        alu_op;
  logic [7:0]        alu_a, alu_b, alu_y, rsp_y;
  logic              alu_cy, alu_st, rsp_st, rsp_cout;
  int                errors = 0, checks = 0;
  alu_arbiter #(.NREQ(NREQ), .LOCK_TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cy(req_cy),
    .req_chain(req_chain), .req_lock(req_lock), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cy(alu_cy), .alu_y(alu_y), .alu_st(alu_st),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_st(rsp_st), .rsp_cout(rsp_cout)
  );
  always #5 clk = ~clk;
  // External ALU: st is signed overflow, CY used by ADC only
  always_comb begin
    alu_y  = 8'h00;
    alu_st = 1'b0;
    if (alu_op == OP_PASS) alu_y = alu_a;
    else if (alu_op == OP_ADC) begin
      alu_y  = alu_a + alu_b + {7'd0, alu_cy};
      alu_st = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
    end else if (alu_op == OP_SUB) begin
      alu_y  = alu_a - alu_b;
      alu_st = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
    end
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int i, input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cy, input logic ch, input logic lk);
    req_valid[i]     = v;
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_cy[i]        = cy;
    req_chain[i]     = ch;
    req_lock[i]      = lk;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_cy = '0; req_chain = '0; req_lock = '0;
    drive(0, 1, OP_PASS, 8'hA0, 8'h00, 0, 0, 0);
    drive(1, 1, OP_PASS, 8'hA1, 8'h00, 0, 0, 0);
    tick(); tick();
    chk("reset_ready", 8'(req_ready), 8'h0);
    chk("reset_rsp_valid", 8'(rsp_valid), 8'h0);
    chk("reset_rsp_y", rsp_y, 8'h00);
    chk("reset_rsp_st_cout", {6'd0, rsp_st, rsp_cout}, 8'h0);
    rst_n = 1'b1;
    #1;
    // Round robin from reset: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 8'(req_ready), (k % 2 == 0) ? 8'h1 : 8'h2);
      tick();
      chk("rr_rsp_valid", 8'(rsp_valid), (k % 2 == 0) ? 8'h1 : 8'h2);
      chk("rr_rsp_y", rsp_y, (k % 2 == 0) ? 8'hA0 : 8'hA1);
    end
    // Idle: ALU driven to zero, response holds
    req_valid = '0;
    #1;
    chk("idle_ready", 8'(req_ready), 8'h0);
    chk("idle_alu", {alu_op, 5'd0, alu_cy} | alu_a | alu_b, 8'h00);
    tick();
    chk("idle_rsp_valid", 8'(rsp_valid), 8'h0);
    chk("idle_rsp_hold", rsp_y, 8'hA1);
    // Single beat ADC with signed overflow
    drive(0, 1, OP_ADC, 8'h70, 8'h10, 1, 0, 0);
    #1;
    chk("single_ready", 8'(req_ready), 8'h1);
    chk("single_alu_cy", {7'd0, alu_cy}, 8'h1);
    tick();
    chk("single_rsp_valid", 8'(rsp_valid), 8'h1);
    chk("single_rsp_y", rsp_y, 8'h81);
    chk("single_rsp_st", {7'd0, rsp_st}, 8'h1);
    chk("single_rsp_cout", {7'd0, rsp_cout}, 8'h0);
    // SUB borrow on req0 (ptr=1 wraps to req0)
    drive(0, 1, OP_SUB, 8'h00, 8'h01, 0, 0, 0);
    tick();
    chk("sub_rsp_y", rsp_y, 8'hFF);
    chk("sub_rsp_cout", {7'd0, rsp_cout}, 8'h1);
    chk("sub_rsp_st", {7'd0, rsp_st}, 8'h0);
    // Chained 16-bit add on req1 while req0 stays valid
    drive(0, 1, OP_PASS, 8'h55, 8'h00, 0, 0, 0);
    drive(1, 1, OP_ADC, 8'hFF, 8'h01, 0, 0, 1);
    #1;
    chk("chain1_ready", 8'(req_ready), 8'h2);
    tick();
    chk("chain1_rsp_valid", 8'(rsp_valid), 8'h2);
    chk("chain1_rsp_y", rsp_y, 8'h00);
    chk("chain1_rsp_cout", {7'd0, rsp_cout}, 8'h1);
    drive(1, 1, OP_ADC, 8'h12, 8'h00, 0, 1, 0);
    #1;
    chk("chain2_ready_locked", 8'(req_ready), 8'h2);
    chk("chain2_alu_cy", {7'd0, alu_cy}, 8'h1);
    tick();
    chk("chain2_rsp_y", rsp_y, 8'h13);
    chk("chain2_rsp_cout", {7'd0, rsp_cout}, 8'h0);
    #1;
    chk("after_chain_ready", 8'(req_ready), 8'h1);
    tick();
    chk("after_chain_rsp_y", rsp_y, 8'h55);
    // Lock timeout: req0 locks with carry out, then idles
    drive(1, 0, OP_PASS, 8'h00, 8'h00, 0, 0, 0);
    drive(0, 1, OP_ADC, 8'hFF, 8'h01, 0, 0, 1);
    tick();
    chk("tmo_lock_cout", {7'd0, rsp_cout}, 8'h1);
    drive(0, 0, OP_PASS, 8'h00, 8'h00, 0, 0, 0);
    drive(1, 1, OP_ADC, 8'h00, 8'h00, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("tmo_blocked", 8'(req_ready), 8'h0);
      tick();
    end
    #1;
    chk("tmo_release_ready", 8'(req_ready), 8'h2);
    chk("tmo_carry_cleared", {7'd0, alu_cy}, 8'h0);
    tick();
    chk("tmo_rsp_valid", 8'(rsp_valid), 8'h2);
    chk("tmo_rsp_y", rsp_y, 8'h00);
    // Reset mid-lock: req1 locks, then reset drops the lock and the in-flight beat
    drive(1, 1, OP_PASS, 8'h22, 8'h00, 0, 0, 1);
    tick();
    chk("rst_lock_rsp_y", rsp_y, 8'h22);
    drive(1, 1, OP_PASS, 8'h33, 8'h00, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 8'(req_ready), 8'h0);
    chk("rst_mid_rsp_valid", 8'(rsp_valid), 8'h0);
    chk("rst_mid_rsp_y", rsp_y, 8'h00);
    tick();
    rst_n = 1'b1;
    drive(0, 1, OP_PASS, 8'h44, 8'h00, 0, 0, 0);
    drive(1, 1, OP_PASS, 8'h66, 8'h00, 0, 0, 0);
    #1;
    chk("post_rst_ready", 8'(req_ready), 8'h1);
    tick();
    chk("post_rst_rsp_valid", 8'(rsp_valid), 8'h1);
    chk("post_rst_rsp_y", rsp_y, 8'h44);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
